// File: rtl/road_fighter_pkg.sv
// Shared types and widths for the player-car speed datapath.
package road_fighter_pkg;
  localparam int SPEED_W   = 5;
  localparam int ACC_W     = 8;
  localparam int MIN_SPEED = 1;

  typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, BRAKE, CRASH} speed_state_t;
endpackage

// File: rtl/update_tick_gen.sv
// Free-running pacing tick: one-cycle registered pulse every CLK_HZ/UPDATE_HZ cycles.
// First pulse lands TICK_DIV cycles after enable rises; no backpressure, held idle while enable=0.
module update_tick_gen #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int UPDATE_HZ = 16
) (
  input  logic clk,
  input  logic resetN,
  input  logic enable,
  output logic tick
);
  localparam int TICK_DIV = CLK_HZ / UPDATE_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/speed_controller.sv
// Player-car speed FSM: gas/brake/crash -> registered speed and acceleration, paced by update_tick.
// All outputs registered (1-cycle latency); no backpressure, speed never drops below MIN_SPEED.
module speed_controller #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int UPDATE_HZ   = 16,
  parameter int MIN_SPEED   = road_fighter_pkg::MIN_SPEED,
  parameter int MAX_SPEED   = 31,
  parameter int ACC_STEP    = 8,
  parameter int BRAKE_STEP  = 2,
  parameter int CRASH_TICKS = 32
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       game_on,
  input  logic       gas,
  input  logic       brake,
  input  logic       crash,
  output logic [4:0] car_speed,
  output logic [7:0] car_acceleration,
  output logic       crash_lock,
  output logic       moving,
  output logic       update_tick
);
  import road_fighter_pkg::*;

  localparam logic [SPEED_W-1:0] SPD_MIN    = SPEED_W'(MIN_SPEED);
  localparam logic [SPEED_W-1:0] SPD_MAX    = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W:0]   BRK_STEP   = (SPEED_W+1)'(BRAKE_STEP);
  localparam logic [SPEED_W:0]   BRK_FLOOR  = (SPEED_W+1)'(MIN_SPEED + BRAKE_STEP);
  localparam logic [ACC_W:0]     ACC_STEP_W = (ACC_W+1)'(ACC_STEP);
  localparam logic [ACC_W-1:0]   ACC_STEP_N = ACC_W'(ACC_STEP);
  localparam int                 CC_W       = $clog2(CRASH_TICKS + 1);
  localparam logic [CC_W-1:0]    CC_LAST    = CC_W'(CRASH_TICKS - 1);

  speed_state_t     state_q, state_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CC_W-1:0]  ccnt_q, ccnt_d;
  logic             lock_q, lock_d;
  logic             moving_q, moving_d;
  logic [ACC_W:0]   acc_sum;
  logic [SPEED_W:0] spd_wide;
  logic             crash_entry;

  update_tick_gen #(
    .CLK_HZ   (CLK_HZ),
    .UPDATE_HZ(UPDATE_HZ)
  ) u_tick (
    .clk   (clk),
    .resetN(resetN),
    .enable(game_on),
    .tick  (update_tick)
  );

  always_comb begin
    state_d     = state_q;
    speed_d     = speed_q;
    acc_d       = acc_q;
    ccnt_d      = ccnt_q;
    acc_sum     = {1'b0, acc_q} + ACC_STEP_W;
    spd_wide    = {1'b0, speed_q};
    crash_entry = game_on && crash && (state_q != IDLE);

    if (!game_on) begin
      state_d = IDLE;
    end else if (crash_entry) begin
      state_d = CRASH;
    end else begin
      case (state_q)
        IDLE:    state_d = CRUISE;
        CRASH:   if (update_tick && ccnt_q == CC_LAST) state_d = CRUISE;
        default: state_d = brake ? BRAKE : (gas ? ACCEL : CRUISE);
      endcase
    end

    // Tick arithmetic follows the registered state; entry actions below override it.
    if (update_tick) begin
      case (state_q)
        ACCEL: begin
          if (!acc_sum[ACC_W]) begin
            acc_d = acc_sum[ACC_W-1:0];
          end else if (speed_q < SPD_MAX) begin
            speed_d = speed_q + SPEED_W'(1);
            acc_d   = acc_sum[ACC_W-1:0];
          end else begin
            acc_d = '1;
          end
        end
        CRUISE:  acc_d   = (acc_q > ACC_STEP_N) ? acc_q - ACC_STEP_N : '0;
        BRAKE:   speed_d = (spd_wide >= BRK_FLOOR) ? SPEED_W'(spd_wide - BRK_STEP) : SPD_MIN;
        CRASH:   ccnt_d  = ccnt_q + CC_W'(1);
        default: ;
      endcase
    end

    if (state_d == IDLE || crash_entry) begin
      speed_d = SPD_MIN;
      acc_d   = '0;
    end
    if (crash_entry) ccnt_d = '0;
    if (state_d == BRAKE && state_q != BRAKE) acc_d = '0;

    lock_d   = (state_d == CRASH);
    moving_d = (state_d == ACCEL) || (state_d == CRUISE) || (state_d == BRAKE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      speed_q  <= SPD_MIN;
      acc_q    <= '0;
      ccnt_q   <= '0;
      lock_q   <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      acc_q    <= acc_d;
      ccnt_q   <= ccnt_d;
      lock_q   <= lock_d;
      moving_q <= moving_d;
    end
  end

  assign car_speed        = speed_q;
  assign car_acceleration = acc_q;
  assign crash_lock       = lock_q;
  assign moving           = moving_q;
endmodule
